mips_multicycle_ctrl: RTL and testbench

//  Multi-cycle control sequencer for the 32-bit MIPS-subset datapath (PC, register file, ALU, single memory port).

---
 rtl/mips_pkg.sv | 39 +++
 rtl/mips_alu_dec.sv | 23 ++
 rtl/mips_multicycle_ctrl.sv | 153 +++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - opcodes, funct codes, ALU ops and state encodings for the multi-cycle MIPS control
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_SLT = 4'b0100;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  function automatic logic opcode_known(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mips_alu_dec.sv
// rtl/mips_alu_dec.sv - R-type funct to ALU opcode decode with legality flag
module mips_alu_dec
  import mips_pkg::*;
(
  input  logic [5:0] funct,
  output logic [3:0] alu_op,
  output logic       legal
);

  always_comb begin
    alu_op = ALU_ADD;
    legal  = 1'b1;
    case (funct)
      FN_ADD: alu_op = ALU_ADD;
      FN_SUB: alu_op = ALU_SUB;
      FN_AND: alu_op = ALU_AND;
      FN_OR:  alu_op = ALU_OR;
      FN_SLT: alu_op = ALU_SLT;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - multi-cycle MIPS control FSM with shared req/ready memory port
// Optional MCTRL_PERF_CNT_EN adds cycle_cnt/instr_cnt performance counters.
module mips_multicycle_ctrl
  import mips_pkg::*;
#(
  parameter int TRAP_ON_ILLEGAL = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        iord,
  output logic        ir_write,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [3:0]  alu_op,
  output logic        reg_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        illegal,
  output logic [2:0]  state
`ifdef MCTRL_PERF_CNT_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instr_cnt
`endif
);

  state_t     cur, nxt;
  logic [3:0] fn_alu_op;
  logic       fn_legal;
  logic       instr_ok;

  mips_alu_dec u_alu_dec (
    .funct  (funct),
    .alu_op (fn_alu_op),
    .legal  (fn_legal)
  );

  // Opcode 0 with an unsupported funct is treated exactly like an unknown opcode.
  assign instr_ok = opcode_known(opcode) && ((opcode != OP_RTYPE) || fn_legal);
  assign state    = cur;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cur <= S_FETCH;
    else     cur <= nxt;
  end

  // Everything is forced low while rst is high so a pending request drops at once.
  always_comb begin
    nxt        = cur;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 2'd0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'd0;
    alu_op     = ALU_ADD;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    illegal    = 1'b0;
    if (!rst) begin
      case (cur)
        S_FETCH: begin
          mem_req   = 1'b1;
          alu_src_b = 2'd1;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            nxt      = S_DECODE;
          end
        end
        S_DECODE: begin
          alu_src_b = 2'd3;
          if (instr_ok)                  nxt = S_EXEC;
          else if (TRAP_ON_ILLEGAL != 0) nxt = S_TRAP;
          else                           nxt = S_FETCH;
        end
        S_EXEC: begin
          case (opcode)
            OP_RTYPE: begin
              alu_src_a = 1'b1;
              alu_op    = fn_alu_op;
              nxt       = S_WB;
            end
            OP_LW, OP_SW: begin
              alu_src_a = 1'b1;
              alu_src_b = 2'd2;
              nxt       = S_MEM;
            end
            OP_ADDI: begin
              alu_src_a = 1'b1;
              alu_src_b = 2'd2;
              nxt       = S_WB;
            end
            OP_BEQ: begin
              alu_src_a = 1'b1;
              alu_op    = ALU_SUB;
              pc_src    = 2'd1;
              pc_write  = zero;
              nxt       = S_FETCH;
            end
            OP_J: begin
              pc_src   = 2'd2;
              pc_write = 1'b1;
              nxt      = S_FETCH;
            end
            default: nxt = S_FETCH;
          endcase
        end
        S_MEM: begin
          mem_req = 1'b1;
          iord    = 1'b1;
          mem_we  = (opcode == OP_SW);
          if (mem_ready) nxt = (opcode == OP_LW) ? S_WB : S_FETCH;
        end
        S_WB: begin
          reg_write  = 1'b1;
          reg_dst    = (opcode == OP_RTYPE);
          mem_to_reg = (opcode == OP_LW);
          nxt        = S_FETCH;
        end
        S_TRAP: begin
          illegal = 1'b1;
          nxt     = S_TRAP;
        end
        default: nxt = S_FETCH;
      endcase
    end
  end

`ifdef MCTRL_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt <= 32'd0;
      instr_cnt <= 32'd0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if ((cur != S_FETCH) && (nxt == S_FETCH)) instr_cnt <= instr_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb/tb_mips_multicycle_ctrl.sv - self-checking bench for mips_multicycle_ctrl
module tb_mips_multicycle_ctrl;
  import mips_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic [5:0] opcode, funct;
  logic zero, mem_ready;
  logic mem_req, mem_we, iord, ir_write, pc_write;
  logic [1:0] pc_src;
  logic alu_src_a;
  logic [1:0] alu_src_b;
  logic [3:0] alu_op;
  logic reg_write, reg_dst, mem_to_reg, illegal;
  logic [2:0] state;
`ifdef MCTRL_PERF_CNT_EN
  logic [31:0] cycle_cnt, instr_cnt;
`endif

  mips_multicycle_ctrl dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .illegal(illegal), .state(state)
`ifdef MCTRL_PERF_CNT_EN
    , .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic req, we, iord, irw, pcw;
    logic [1:0] pcs;
    logic sa;
    logic [1:0] sb;
    logic [3:0] aop;
    logic rw, rd, m2r, ill;
  } out_t;

  typedef struct {
    logic rdy;
    logic z;
    out_t exp;
  } cyc_t;

  typedef struct {
    string name;
    logic [5:0] op;
    logic [5:0] fn;
    logic z;
    int fw;
    int mw;
    int lat;
  } vec_t;

  cyc_t q[$];
  int tests = 0;
  int fails = 0;

  function automatic out_t mk(input logic [2:0] st);
    out_t e;
    e = '0;
    e.st = st;
    return e;
  endfunction

  function automatic logic fn_ok(input logic [5:0] fn);
    return fn inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
  endfunction

  function automatic logic [3:0] fn_alu(input logic [5:0] fn);
    case (fn)
      FN_SUB:  return ALU_SUB;
      FN_AND:  return ALU_AND;
      FN_OR:   return ALU_OR;
      FN_SLT:  return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

  // Zero-wait latency per instruction class, plus one cycle per wait cycle.
  function automatic int lat_of(input logic [5:0] op, input int fw, input int mw);
    int base;
    case (op)
      OP_BEQ, OP_J: base = 3;
      OP_LW:        base = 5;
      default:      base = 4;
    endcase
    return base + fw + ((op == OP_LW || op == OP_SW) ? mw : 0);
  endfunction

  task automatic push(input logic rdy, input logic z, input out_t e);
    cyc_t c;
    c.rdy = rdy;
    c.z   = z;
    c.exp = e;
    q.push_back(c);
  endtask

  // Expected per-cycle output trace of one instruction, built phase by phase.
  task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input int fw, input int mw);
    out_t e;
    logic ok;
    q.delete();
    ok = (op == OP_RTYPE) ? fn_ok(fn) : (op inside {OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J});
    for (int i = 0; i <= fw; i++) begin
      e = mk(3'd0); e.req = 1'b1; e.sb = 2'd1;
      if (i == fw) begin e.irw = 1'b1; e.pcw = 1'b1; end
      push(i == fw, z, e);
    end
    e = mk(3'd1); e.sb = 2'd3;
    push(1'($urandom % 2), z, e);
    if (!ok) return;
    e = mk(3'd2);
    if (op == OP_RTYPE) begin e.sa = 1'b1; e.aop = fn_alu(fn); end
    else if (op == OP_BEQ) begin e.sa = 1'b1; e.aop = ALU_SUB; e.pcs = 2'd1; e.pcw = z; end
    else if (op == OP_J) begin e.pcs = 2'd2; e.pcw = 1'b1; end
    else begin e.sa = 1'b1; e.sb = 2'd2; end
    push(1'($urandom % 2), z, e);
    if (op == OP_LW || op == OP_SW) begin
      for (int i = 0; i <= mw; i++) begin
        e = mk(3'd3); e.req = 1'b1; e.iord = 1'b1; e.we = (op == OP_SW);
        push(i == mw, z, e);
      end
    end
    if (op == OP_RTYPE || op == OP_ADDI || op == OP_LW) begin
      e = mk(3'd4); e.rw = 1'b1; e.rd = (op == OP_RTYPE); e.m2r = (op == OP_LW);
      push(1'($urandom % 2), z, e);
    end
  endtask

  task automatic chk(input string name, input int idx, input out_t exp);
    out_t act;
    act = {state, mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_a,
           alu_src_b, alu_op, reg_write, reg_dst, mem_to_reg, illegal};
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Applies the queued trace; called at posedge+1 with the DUT in FETCH.
  task automatic run(input string name, input logic [5:0] op, input logic [5:0] fn,
                     output int lat);
    logic left;
    lat = -1;
    left = 1'b0;
    opcode = op;
    funct = fn;
    for (int i = 0; i < q.size(); i++) begin
      mem_ready = q[i].rdy;
      zero = q[i].z;
      @(negedge clk);
      chk(name, i, q[i].exp);
      if (state != 3'd0) left = 1'b1;
      else if (left && lat < 0) lat = i;
      @(posedge clk); #1;
    end
    mem_ready = 1'b0;
    @(negedge clk);
    if (left && lat < 0 && state == 3'd0) lat = q.size();
    @(posedge clk); #1;
  endtask

  vec_t tbl[8];
  int lat;
  out_t e;

  initial begin
    tbl[0] = '{"add",   OP_RTYPE, FN_ADD, 1'b0, 0, 0, 4};
    tbl[1] = '{"lw_w2", OP_LW,    6'd0,   1'b0, 0, 2, 7};
    tbl[2] = '{"beq_t", OP_BEQ,   6'd0,   1'b1, 0, 0, 3};
    tbl[3] = '{"beq_n", OP_BEQ,   6'd0,   1'b0, 0, 0, 3};
    tbl[4] = '{"sw",    OP_SW,    6'd0,   1'b0, 0, 0, 4};
    tbl[5] = '{"j",     OP_J,     6'd0,   1'b1, 0, 0, 3};
    tbl[6] = '{"addi_f",OP_ADDI,  6'd0,   1'b0, 2, 0, 6};
    tbl[7] = '{"slt",   OP_RTYPE, FN_SLT, 1'b0, 1, 0, 5};

    rst = 1'b1; opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;
    #2;
    chk("reset", 0, mk(3'd0));
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    foreach (tbl[k]) begin
      build(tbl[k].op, tbl[k].fn, tbl[k].z, tbl[k].fw, tbl[k].mw);
      run(tbl[k].name, tbl[k].op, tbl[k].fn, lat);
      chk_int({tbl[k].name, "_latency"}, lat, tbl[k].lat);
    end

    for (int r = 0; r < 40; r++) begin
      logic [5:0] op, fn;
      int fw, mw;
      fn = 6'd0;
      case ($urandom_range(0, 9))
        0: begin op = OP_RTYPE; fn = FN_ADD; end
        1: begin op = OP_RTYPE; fn = FN_SUB; end
        2: begin op = OP_RTYPE; fn = FN_AND; end
        3: begin op = OP_RTYPE; fn = FN_OR;  end
        4: begin op = OP_RTYPE; fn = FN_SLT; end
        5: op = OP_LW;
        6: op = OP_SW;
        7: op = OP_ADDI;
        8: op = OP_BEQ;
        default: op = OP_J;
      endcase
      fw = $urandom_range(0, 3);
      mw = $urandom_range(0, 3);
      build(op, fn, 1'($urandom % 2), fw, mw);
      run("rand", op, fn, lat);
      chk_int("rand_latency", lat, lat_of(op, fw, mw));
    end

    // Illegal opcode, then illegal funct under opcode 0: both must park in TRAP.
    for (int t = 0; t < 2; t++) begin
      logic [5:0] op, fn;
      op = (t == 0) ? 6'b111111 : OP_RTYPE;
      fn = (t == 0) ? FN_ADD : 6'b111111;
      build(op, fn, 1'b0, 0, 0);
      run("illegal_entry", op, fn, lat);
      for (int i = 0; i < 20; i++) begin
        mem_ready = 1'($urandom % 2);
        zero = 1'($urandom % 2);
        @(negedge clk);
        e = mk(3'd5); e.ill = 1'b1;
        chk("trap_hold", i, e);
        @(posedge clk); #1;
      end
      rst = 1'b1;
      #1;
      chk("trap_rst", 0, mk(3'd0));
      @(negedge clk); rst = 1'b0; mem_ready = 1'b0;
      @(posedge clk); #1;
    end

    // Reset while FETCH waits on memory.
    opcode = OP_LW; mem_ready = 1'b0;
    @(negedge clk);
    e = mk(3'd0); e.req = 1'b1; e.sb = 2'd1;
    chk("fetch_wait", 0, e);
    @(posedge clk); #1;
    @(negedge clk);
    chk("fetch_wait", 1, e);
    #2 rst = 1'b1;
    #1;
    chk("fetch_rst", 0, mk(3'd0));
`ifdef MCTRL_PERF_CNT_EN
    chk_int("cycle_cnt_rst", int'(cycle_cnt), 0);
    chk_int("instr_cnt_rst", int'(instr_cnt), 0);
`endif
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
